fifo_rr_scheduler: RTL

- Shares the team's single 8-bit synchronous FIFO between NUM_REQ producers using round-robin write arbitration.
- Drains the FIFO into one downstream valid/ready stream, absorbing the FIFO's one-cycle registered read latency.
- Sits directly on the FIFO's wr/rd/in/out/full/empty pins; the FIFO itself is instantiated alongside it, not inside it.

---
 rtl/fifo_rr_scheduler_pkg.sv | 18 +
 rtl/fifo_rr_scheduler_if.sv | 33 +++
 rtl/fifo_rr_scheduler_rr_grant.sv | 32 +++
 rtl/fifo_rr_scheduler.sv | 125 ++++++++++++
 4 files changed

// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared definitions for the FIFO round-robin scheduler: default word width,
// read-side FSM encoding and the grant-index width helper.
package fifo_rr_scheduler_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_PEND = 2'd1,
        VALID   = 2'd2
    } rd_state_t;

    // Width of a producer index; a single producer still needs one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// Bundles the producer handshakes, the FIFO pins and the downstream stream.
// master = scheduler side, slave = environment (producers, FIFO, sink).
interface fifo_rr_scheduler_if
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_in;
    logic                      fifo_full;
    logic                      fifo_rd;
    logic [DATA_W-1:0]         fifo_out;
    logic                      fifo_empty;

    logic                      m_valid;
    logic [DATA_W-1:0]         m_data;
    logic                      m_ready;

    modport master (
        input  req_valid, req_data, fifo_full, fifo_out, fifo_empty, m_ready,
        output req_ready, fifo_wr, fifo_in, fifo_rd, m_valid, m_data
    );

    modport slave (
        output req_valid, req_data, fifo_full, fifo_out, fifo_empty, m_ready,
        input  req_ready, fifo_wr, fifo_in, fifo_rd, m_valid, m_data
    );
endinterface

// File: rtl/fifo_rr_scheduler_rr_grant.sv
// Pure-combinational round-robin picker: scans req starting one past the
// last winner, wrapping around, and reports the first set bit.
module rr_grant #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_gnt
);

    // Walk the ring from last+1; only the first hit is latched into the outputs.
    always_comb begin
        int   cand_s;
        logic hit_s;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            cand_s       = (int'(last) + off) % N;
            hit_s        = req[cand_s] & ~any_gnt;
            gnt[cand_s]  = gnt[cand_s] | hit_s;
            gnt_idx      = hit_s ? IDX_W'(cand_s) : gnt_idx;
            any_gnt      = any_gnt | hit_s;
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Round-robin write arbiter and read-side drainer for an external 8-bit
// synchronous FIFO with one-cycle registered read data.
module fifo_rr_scheduler
    import fifo_rr_scheduler_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = DATA_W_DEF,
    parameter int  CNT_W   = 16,
    localparam int GID_W   = grant_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_rr_scheduler_if.master  bus,
    output logic [GID_W-1:0]     grant_id,
    output logic [CNT_W-1:0]     accepted_cnt
);

    logic [NUM_REQ-1:0] gnt_s;
    logic [GID_W-1:0]   gnt_idx_s;
    logic               any_s;
    logic               wr_s;
    logic [DATA_W-1:0]  wr_data_s;
    logic               rd_s;
    logic [GID_W-1:0]   last_grant_r;
    logic [GID_W-1:0]   grant_id_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  m_data_r;
    rd_state_t          state_r;
    rd_state_t          state_nx_s;

    rr_grant #(
        .N     (NUM_REQ),
        .IDX_W (GID_W)
    ) u_rr_grant (
        .req     (bus.req_valid),
        .last    (last_grant_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any_gnt (any_s)
    );

    // Write handshake: grant uses only valid and full, never ready.
    always_comb begin
        wr_s      = any_s & ~bus.fifo_full;
        wr_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            wr_data_s = wr_data_s | (bus.req_data[i*DATA_W +: DATA_W] & {DATA_W{gnt_s[i]}});
        end
    end

    assign bus.fifo_wr   = wr_s;
    assign bus.fifo_in   = wr_data_s;
    assign bus.req_ready = wr_s ? gnt_s : {NUM_REQ{1'b0}};

    // Arbitration pointer, reported grant index and saturating accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= GID_W'(NUM_REQ - 1);
            grant_id_r   <= '0;
            cnt_r        <= '0;
        end else if (wr_s) begin
            last_grant_r <= gnt_idx_s;
            grant_id_r   <= gnt_idx_s;
            cnt_r        <= (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        end
    end

    assign grant_id     = grant_id_r;
    assign accepted_cnt = cnt_r;

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Read FSM next state; a read is only issued when no word is held or pending.
    always_comb begin
        state_nx_s = state_r;
        rd_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_s       = 1'b1;
                    state_nx_s = RD_PEND;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD_PEND: begin
                state_nx_s = VALID;
            end
            VALID: begin
                if (bus.m_ready && !bus.fifo_empty) begin
                    rd_s       = 1'b1;
                    state_nx_s = RD_PEND;
                end else if (bus.m_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = VALID;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Capture the FIFO's registered read word the cycle after the read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_r <= '0;
        end else if (state_r == RD_PEND) begin
            m_data_r <= bus.fifo_out;
        end
    end

    assign bus.fifo_rd = rd_s;
    assign bus.m_valid = (state_r == VALID);
    assign bus.m_data  = m_data_r;

endmodule
